// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: two-stage registered datapath that resolves
// conditional branches, JAL and JALR, flags mispredicts and keeps stats.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             kills every in-flight entry at the next edge
//   in_*              request bundle, valid/ready handshake
//   out_*             resolved result, valid/ready handshake
//   cnt_resolved      saturating count of output handshakes
//   cnt_mispredict    saturating count of mispredicting handshakes
module branch_resolve_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_resolved,
    output logic [CNT_W-1:0] cnt_mispredict
);

    localparam logic [1:0] OP_BR   = 2'b00;
    localparam logic [1:0] OP_JAL  = 2'b01;
    localparam logic [1:0] OP_JALR = 2'b10;

    localparam logic [XLEN-1:0]  FOUR    = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // S1: registered request
    logic            s1_valid;
    logic [1:0]      s1_op;
    logic [2:0]      s1_funct3;
    logic [XLEN-1:0] s1_pc;
    logic [XLEN-1:0] s1_a;
    logic [XLEN-1:0] s1_b;
    logic [XLEN-1:0] s1_imm;
    logic            s1_pred_taken;
    logic [XLEN-1:0] s1_pred_target;

    // S2: registered result
    logic            s2_valid;
    logic            s2_taken;
    logic [XLEN-1:0] s2_target;
    logic [XLEN-1:0] s2_link;
    logic            s2_mispredict;
    logic [XLEN-1:0] s2_redirect;
    logic            s2_illegal;

    logic s2_adv;
    logic s1_adv;
    logic out_fire;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign out_fire = s2_valid && out_ready;

    // Resolution of the S1 entry
    logic            cond;
    logic            r_taken;
    logic            r_illegal;
    logic            r_mispredict;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_link;
    logic [XLEN-1:0] sum_pc;
    logic [XLEN-1:0] sum_a;

    always_comb begin
        sum_pc = s1_pc + s1_imm;
        sum_a  = s1_a + s1_imm;
        r_link = s1_pc + FOUR;
        cond   = 1'b0;
        case (s1_funct3)
            3'b000:  cond = (s1_a == s1_b);
            3'b001:  cond = (s1_a != s1_b);
            3'b100:  cond = ($signed(s1_a) <  $signed(s1_b));
            3'b101:  cond = ($signed(s1_a) >= $signed(s1_b));
            3'b110:  cond = (s1_a <  s1_b);
            3'b111:  cond = (s1_a >= s1_b);
            default: cond = 1'b0;
        endcase
        r_taken   = 1'b0;
        r_illegal = 1'b0;
        r_target  = sum_pc;
        case (s1_op)
            OP_BR: begin
                r_taken   = cond;
                r_illegal = (s1_funct3[2:1] == 2'b01);
            end
            OP_JAL: r_taken = 1'b1;
            OP_JALR: begin
                r_taken  = 1'b1;
                r_target = {sum_a[XLEN-1:1], 1'b0};
            end
            default: r_illegal = 1'b1;
        endcase
        // Illegal entries never redirect the front end
        r_mispredict = !r_illegal &&
                       ((r_taken != s1_pred_taken) ||
                        (r_taken && (r_target != s1_pred_target)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_op          <= '0;
            s1_funct3      <= '0;
            s1_pc          <= '0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_imm         <= '0;
            s1_pred_taken  <= 1'b0;
            s1_pred_target <= '0;
            s2_valid       <= 1'b0;
            s2_taken       <= 1'b0;
            s2_target      <= '0;
            s2_link        <= '0;
            s2_mispredict  <= 1'b0;
            s2_redirect    <= '0;
            s2_illegal     <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op          <= in_op;
                    s1_funct3      <= in_funct3;
                    s1_pc          <= in_pc;
                    s1_a           <= in_a;
                    s1_b           <= in_b;
                    s1_imm         <= in_imm;
                    s1_pred_taken  <= in_pred_taken;
                    s1_pred_target <= in_pred_target;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_taken      <= r_taken;
                    s2_target     <= r_target;
                    s2_link       <= r_link;
                    s2_mispredict <= r_mispredict;
                    s2_redirect   <= r_taken ? r_target : r_link;
                    s2_illegal    <= r_illegal;
                end
            end
        end
    end

    // A handshake coinciding with flush still completes and is counted
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_resolved   <= '0;
            cnt_mispredict <= '0;
        end else if (out_fire) begin
            if (cnt_resolved != '1)
                cnt_resolved <= cnt_resolved + CNT_ONE;
            if (s2_mispredict && (cnt_mispredict != '1))
                cnt_mispredict <= cnt_mispredict + CNT_ONE;
        end
    end

    assign out_valid       = s2_valid;
    assign out_taken       = s2_taken;
    assign out_target      = s2_target;
    assign out_link        = s2_link;
    assign out_mispredict  = s2_mispredict;
    assign out_redirect_pc = s2_redirect;
    assign out_illegal     = s2_illegal;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Drives inputs 1ns after posedge, samples before the next posedge.
module tb_branch_resolve_unit;

    localparam logic [1:0] OP_BR   = 2'b00;
    localparam logic [1:0] OP_JAL  = 2'b01;
    localparam logic [1:0] OP_JALR = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [2:0]  in_funct3;
    logic [63:0] in_pc, in_a, in_b, in_imm, in_pred_target;
    logic        in_pred_taken;
    logic        out_ready;

    logic        in_ready, out_valid, out_taken, out_mispredict, out_illegal;
    logic [63:0] out_target, out_link, out_redirect_pc;
    logic [31:0] cnt_resolved, cnt_mispredict;

    logic        s_in_ready, s_out_valid, s_out_taken;
    logic        s_out_mispredict, s_out_illegal;
    logic [63:0] s_out_target, s_out_link, s_out_redirect_pc;
    logic [1:0]  s_cnt_resolved, s_cnt_mispredict;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3),
        .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target),
        .out_link(out_link), .out_mispredict(out_mispredict),
        .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal),
        .cnt_resolved(cnt_resolved), .cnt_mispredict(cnt_mispredict)
    );

    branch_resolve_unit #(.XLEN(64), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_funct3(in_funct3),
        .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_taken(s_out_taken), .out_target(s_out_target),
        .out_link(s_out_link), .out_mispredict(s_out_mispredict),
        .out_redirect_pc(s_out_redirect_pc), .out_illegal(s_out_illegal),
        .cnt_resolved(s_cnt_resolved), .cnt_mispredict(s_cnt_mispredict)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                         input logic [63:0] pc, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm,
                         input logic pt, input logic [63:0] ptgt);
        in_valid       = 1'b1;
        in_op          = op;
        in_funct3      = f3;
        in_pc          = pc;
        in_a           = a;
        in_b           = b;
        in_imm         = imm;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one request with out_ready=1; returns at the out_valid cycle
    task automatic run_one(input logic [1:0] op, input logic [2:0] f3,
                           input logic [63:0] pc, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] imm,
                           input logic pt, input logic [63:0] ptgt);
        int lat;
        out_ready = 1'b1;
        drive(op, f3, pc, a, b, imm, pt, ptgt);
        #3;
        check("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, 2);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_cnt_res"}, cnt_resolved, 0);
        check({tag, "_cnt_mis"}, cnt_mispredict, 0);
        check({tag, "_target"}, out_target, 0);
        check({tag, "_redirect"}, out_redirect_pc, 0);
        check({tag, "_sat_cnt_res"}, s_cnt_resolved, 0);
    endtask

    logic [63:0] hold_tgt, hold_link, exp_tgt, spc;
    logic [31:0] c0;
    int cyc, sent, recv, lows;
    logic held, acc;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_op = '0; in_funct3 = '0;
        in_pc = '0; in_a = '0; in_b = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_target = '0;
        step(); step();
        rst = 1'b0;
        check_reset_state("rst");

        // BLT signed: -1 < 1 taken
        run_one(OP_BR, 3'b100, 64'h1000, '1, 64'd1, 64'h40, 1'b0, 64'h0);
        check("blt_taken", out_taken, 1);
        check("blt_target", out_target, 64'h1040);
        check("blt_mis", out_mispredict, 1);
        check("blt_redir", out_redirect_pc, 64'h1040);
        check("blt_link", out_link, 64'h1004);

        // BLTU: 0xFF..FF < 1 false
        run_one(OP_BR, 3'b110, 64'h1000, '1, 64'd1, 64'h40, 1'b0, 64'h0);
        check("bltu_taken", out_taken, 0);
        check("bltu_mis", out_mispredict, 0);
        check("bltu_redir", out_redirect_pc, 64'h1004);

        // JALR: (0x2003+0x10) & ~1 = 0x2012
        run_one(OP_JALR, 3'b000, 64'h3000, 64'h2003, 64'h0, 64'h10,
                1'b1, 64'h2012);
        check("jalr_target", out_target, 64'h2012);
        check("jalr_link", out_link, 64'h3004);
        check("jalr_taken", out_taken, 1);
        check("jalr_mis", out_mispredict, 0);
        run_one(OP_JALR, 3'b000, 64'h3000, 64'h2003, 64'h0, 64'h10,
                1'b1, 64'h2010);
        check("jalr_mis2", out_mispredict, 1);

        // JAL: target pc+imm, predicted correctly
        run_one(OP_JAL, 3'b000, 64'h500, 64'h0, 64'h0, 64'h20,
                1'b1, 64'h520);
        check("jal_target", out_target, 64'h520);
        check("jal_mis", out_mispredict, 0);

        // Illegal funct3 and reserved op
        run_one(OP_BR, 3'b010, 64'h100, 64'h7, 64'h7, 64'h8, 1'b1, 64'h108);
        check("f3_taken", out_taken, 0);
        check("f3_illegal", out_illegal, 1);
        check("f3_mis", out_mispredict, 0);
        run_one(OP_RSV, 3'b000, 64'h100, 64'h7, 64'h7, 64'h8, 1'b1, 64'h108);
        check("rsv_taken", out_taken, 0);
        check("rsv_illegal", out_illegal, 1);
        check("rsv_mis", out_mispredict, 0);

        // Address wrap
        run_one(OP_BR, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5, 64'h5,
                64'h8, 1'b1, 64'h4);
        check("wrap_target", out_target, 64'h4);
        check("wrap_link", out_link, 64'h0);
        check("wrap_illegal", out_illegal, 0);
        check("wrap_mis", out_mispredict, 0);
        step();
        check("drain", out_valid, 0);

        // Stream of 8 with a 3-cycle stall
        cyc = 0; sent = 0; recv = 0; lows = 0; held = 1'b0;
        while (recv < 8 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc < 8);
            spc = 64'h100 * (sent + 1);
            if (sent < 8)
                drive(OP_BR, 3'b000, spc, 64'h5, 64'h5, 64'h10,
                      1'b1, spc + 64'h10);
            else
                in_valid = 1'b0;
            #3;
            if (held && out_valid) begin
                check("stall_target", out_target, hold_tgt);
                check("stall_link", out_link, hold_link);
            end
            held = out_valid && !out_ready;
            hold_tgt = out_target;
            hold_link = out_link;
            if (in_valid && !in_ready) begin
                lows++;
                check("ready_low_s2_full", out_valid, 1);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                exp_tgt = 64'h100 * (recv + 1) + 64'h10;
                check("order", out_target, exp_tgt);
                recv++;
            end
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", recv, 8);
        check("stream_ready_lows", lows, 3);
        check("stream_no_dup", out_valid, 0);

        // Flush with two entries in flight
        out_ready = 1'b0;
        drive(OP_JAL, 3'b000, 64'hA00, 64'h0, 64'h0, 64'h4, 1'b1, 64'hA04);
        step();
        drive(OP_JAL, 3'b000, 64'hB00, 64'h0, 64'h0, 64'h4, 1'b1, 64'hB04);
        step();
        drive(OP_JAL, 3'b000, 64'hC00, 64'h0, 64'h0, 64'h4, 1'b1, 64'hC04);
        flush = 1'b1;
        out_ready = 1'b1;
        c0 = cnt_resolved;
        #3;
        check("flush_in_ready", in_ready, 0);
        check("flush_s2_valid", out_valid, 1);
        check("flush_s2_target", out_target, 64'hA04);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_next1", out_valid, 0);
        check("flush_cnt", cnt_resolved, c0 + 32'd1);
        step();
        check("flush_next2", out_valid, 0);
        step();
        check("flush_next3", out_valid, 0);

        // Saturation on the CNT_W=2 instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst2");
        for (int i = 0; i < 5; i++)
            run_one(OP_BR, 3'b100, 64'h1000, '1, 64'd1, 64'h40,
                    1'b0, 64'h0);
        step();
        check("sat_res", s_cnt_resolved, 3);
        check("sat_mis", s_cnt_mispredict, 3);
        check("wide_res", cnt_resolved, 5);
        check("wide_mis", cnt_mispredict, 5);

        // Reset mid-operation
        drive(OP_BR, 3'b100, 64'h1000, '1, 64'd1, 64'h40, 1'b0, 64'h0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst3");
        check("rst3_sat_mis", s_cnt_mispredict, 0);
        step();
        check("rst3_discard", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
